// File: rtl/pipelined_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_adder: WIDTH-bit adder, one CHUNK-bit slice per pipeline stage. |
// | Optional subtract mode: PIPELINED_ADDER_SUB_EN.   Rev 1.0                 |
// +--------------------------------------------------------------------------+
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic [WIDTH-1:0] a_src  [STAGES];
  logic [WIDTH-1:0] b_src  [STAGES];
  logic [WIDTH-1:0] s_src  [STAGES];
  logic             c_src  [STAGES];
  logic             v_src  [STAGES];

  logic [WIDTH-1:0] a_q    [STAGES];
  logic [WIDTH-1:0] b_q    [STAGES];
  logic [WIDTH-1:0] s_q    [STAGES];
  logic             c_q    [STAGES];
  logic             v_q    [STAGES];

  logic [CHUNK:0]   slice  [STAGES];
  logic [WIDTH-1:0] s_next [STAGES];
  logic             ov_next;
  logic             ov_q;

`ifdef PIPELINED_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Operands are zeroed while idle so bubbles carry zeros and inputs never leak out.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_head
      assign a_src[k] = in_valid ? a : '0;
      assign b_src[k] = in_valid ? b_eff : '0;
      assign s_src[k] = '0;
      assign c_src[k] = in_valid & cin_eff;
      assign v_src[k] = in_valid;
    end else begin : g_body
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign v_src[k] = v_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      slice[k]  = {1'b0, a_src[k][k*CHUNK +: CHUNK]}
                + {1'b0, b_src[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, c_src[k]};
      s_next[k] = s_src[k];
      s_next[k][k*CHUNK +: CHUNK] = slice[k][CHUNK-1:0];
    end
    // Carry into the MSB is recovered from the MSB sum bit, then compared with cout.
    ov_next = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1]
            ^ s_next[LAST][WIDTH-1] ^ slice[LAST][CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        s_q[k] <= s_next[k];
        c_q[k] <= slice[k][CHUNK];
        v_q[k] <= v_src[k];
      end
      ov_q <= ov_next;
    end
  end

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// Directed self-checking bench for pipelined_adder (WIDTH=32, CHUNK=8).
module tb_pipelined_adder;

  localparam int LAT = 4;
  localparam logic [31:0] VA [16] = '{
    32'h00000000, 32'hFFFFFFFF, 32'h12345678, 32'h80000000,
    32'h7FFFFFFF, 32'h000000FF, 32'h0000FFFF, 32'h00FFFFFF,
    32'hAAAAAAAA, 32'h55555555, 32'hDEADBEEF, 32'h00000001,
    32'hFFFF0000, 32'h8000FFFF, 32'h0F0F0F0F, 32'hCAFEBABE};
  localparam logic [31:0] VB [16] = '{
    32'h00000000, 32'h00000001, 32'h87654321, 32'h80000000,
    32'h00000000, 32'h00000001, 32'h00000001, 32'h00000001,
    32'h55555555, 32'h55555555, 32'h21524111, 32'hFFFFFFFF,
    32'h0000FFFF, 32'h7FFF0001, 32'hF0F0F0F0, 32'h35014542};
  localparam logic [15:0] VC      = 16'hA5C3;
  localparam logic [3:0]  RDY_PAT = 4'b1001;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, overflow;
  logic [31:0] a, b, sum;
`ifdef PIPELINED_ADDER_SUB_EN
  logic        sub;
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  // Reference: returns {overflow, cout, sum} for addition.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] r;
    logic        ov;
    r  = {1'b0, x} + {1'b0, y} + {32'd0, c};
    ov = (x[31] == y[31]) && (r[31] != x[31]);
    return {ov, r[32], r[31:0]};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
    sub = 1'b0;
`endif
    step(); step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    step();
  endtask

  // One isolated operation: checks latency and result, with garbage on idle inputs.
  task automatic run_one(input string name, input logic [31:0] x, input logic [31:0] y, input logic c,
                         input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    out_ready = 1'b1;
    a = x; b = y; cin = c; in_valid = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready); end
    step();
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678; cin = 1'b1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    n_vec++; if (lat != LAT) begin n_err++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
    n_vec++; if (sum !== es) begin n_err++; $display("FAIL %s_sum: got %h expected %h", name, sum, es); end
    n_vec++; if (cout !== ec) begin n_err++; $display("FAIL %s_cout: got %b expected %b", name, cout, ec); end
    n_vec++; if (overflow !== eo) begin n_err++; $display("FAIL %s_overflow: got %b expected %b", name, overflow, eo); end
    step();
  endtask

  task automatic test_single;
    run_one("carry_s0_s1", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
  endtask

  task automatic test_ripple;
    run_one("full_ripple", 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
    run_one("signed_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic [33:0] expq[$];
    logic [33:0] e;
    int sent = 0, got = 0, first = -1, last = -1, cyc = 0;
    out_ready = 1'b1;
    while ((sent < 16 || got < 16) && cyc < 60) begin
      in_valid = (sent < 16);
      if (sent < 16) begin a = VA[sent]; b = VB[sent]; cin = VC[sent]; end
      #1;
      if (out_valid && out_ready) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL stream_extra: got %h with no pending operand", sum);
        end else begin
          e = expq.pop_front();
          if ({overflow, cout, sum} !== e) begin
            n_err++; $display("FAIL stream_result[%0d]: got %h expected %h", got, {overflow, cout, sum}, e);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    n_vec++; if (got != 16) begin n_err++; $display("FAIL stream_count: got %0d expected 16", got); end
    n_vec++; if (last - first != 15) begin n_err++; $display("FAIL stream_consecutive: got span %0d expected 15", last - first); end
  endtask

  task automatic test_backpressure;
    logic [33:0] expq[$];
    logic [33:0] e, held;
    logic        prev_hold = 1'b0;
    int sent = 0, got = 0, cyc = 0, extra = 0;
    held = '0;
    while ((sent < 8 || got < 8) && cyc < 100) begin
      out_ready = RDY_PAT[cyc % 4];
      in_valid  = (sent < 8);
      if (sent < 8) begin a = VA[sent + 4]; b = VB[sent + 4]; cin = VC[sent + 4]; end
      #1;
      n_vec++;
      if (in_ready !== (out_ready | ~out_valid)) begin
        n_err++; $display("FAIL bp_in_ready: got %b expected %b", in_ready, out_ready | ~out_valid);
      end
      if (prev_hold) begin
        n_vec++;
        if (out_valid !== 1'b1 || {overflow, cout, sum} !== held) begin
          n_err++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", out_valid, {overflow, cout, sum}, held);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++; $display("FAIL bp_extra: got %h with no pending operand", sum);
        end else begin
          e = expq.pop_front();
          if ({overflow, cout, sum} !== e) begin
            n_err++; $display("FAIL bp_result[%0d]: got %h expected %h", got, {overflow, cout, sum}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(model(a, b, cin));
        sent++;
      end
      prev_hold = out_valid && !out_ready;
      held      = {overflow, cout, sum};
      step();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra++;
      step();
    end
    n_vec++; if (got != 8) begin n_err++; $display("FAIL bp_count: got %0d expected 8", got); end
    n_vec++; if (extra != 0) begin n_err++; $display("FAIL bp_duplicate: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_reset_midflight;
    int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      a = VA[i]; b = VB[i]; cin = VC[i]; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
    n_vec++; if (sum !== 32'h0) begin n_err++; $display("FAIL mid_async_sum: got %h expected 00000000", sum); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_flushed: got %0d results expected 0", seen); end
    run_one("after_reset", 32'h00010000, 32'h0000FFFF, 1'b1, 32'h00020000, 1'b0, 1'b0);
  endtask

`ifdef PIPELINED_ADDER_SUB_EN
  task automatic test_sub;
    sub = 1'b1;
    run_one("sub_borrow", 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    sub = 1'b1;
    run_one("sub_ovf",    32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    sub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef PIPELINED_ADDER_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
